// File: rtl/dbus_bridge_pkg.sv
// Shared definitions for the data-bus bridge: address map defaults,
// read FSM encoding, target select and the error read-data pattern.
package dbus_bridge_pkg;

  localparam logic [31:0] DMEM_BASE_DEF = 32'h0000_0000;
  localparam logic [31:0] DMEM_SIZE_DEF = 32'h0002_0000;
  localparam logic [31:0] MMIO_BASE_DEF = 32'h9000_0000;
  localparam logic [31:0] MMIO_SIZE_DEF = 32'h0000_1000;

  // Read data returned when a memory read times out.
  localparam logic [31:0] BUS_ERR_DATA = 32'hDEAD_BEEF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_MEM,
    ST_WAIT_IO,
    ST_ERR,
    ST_DRAIN
  } rd_state_e;

  typedef enum logic [1:0] {
    SEL_MEM,
    SEL_IO,
    SEL_NONE
  } tgt_sel_e;

endpackage

// File: rtl/dbus_decode.sv
// Address decoder: maps a bus address to memory, MMIO or unmapped.
// Offsets are unsigned 32-bit, so an address below a base wraps and misses.
module dbus_decode import dbus_bridge_pkg::*; #(
  parameter logic [31:0] DMEM_BASE = DMEM_BASE_DEF,
  parameter logic [31:0] DMEM_SIZE = DMEM_SIZE_DEF,
  parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEF,
  parameter logic [31:0] MMIO_SIZE = MMIO_SIZE_DEF
) (
  input  logic [31:0] addr,
  output tgt_sel_e    sel
);

  logic [31:0] mem_off;
  logic [31:0] io_off;

  // Range check by offset from each window base; memory wins on overlap.
  always_comb begin
    mem_off = addr - DMEM_BASE;
    io_off  = addr - MMIO_BASE;
    sel     = SEL_NONE;
    if (mem_off < DMEM_SIZE)     sel = SEL_MEM;
    else if (io_off < MMIO_SIZE) sel = SEL_IO;
  end

endmodule

// File: rtl/dbus_bridge.sv
// Core data-bus bridge: routes writes combinationally to data memory or
// MMIO, and tracks a single outstanding read with a small FSM that turns
// unmapped reads and memory timeouts into error responses.
module dbus_bridge import dbus_bridge_pkg::*; #(
  parameter logic [31:0] DMEM_BASE = DMEM_BASE_DEF,
  parameter logic [31:0] DMEM_SIZE = DMEM_SIZE_DEF,
  parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEF,
  parameter logic [31:0] MMIO_SIZE = MMIO_SIZE_DEF,
  parameter int          TIMEOUT   = 16
) (
  input  logic        clk,
  input  logic        resetb,
  // core write port
  input  logic        core_wready,
  output logic        core_wvalid,
  input  logic [31:0] core_waddr,
  input  logic [31:0] core_wdata,
  input  logic [3:0]  core_wstrb,
  // core read port
  input  logic        core_rready,
  output logic        core_rvalid,
  input  logic [31:0] core_raddr,
  output logic        core_rresp,
  output logic [31:0] core_rdata,
  // data memory
  output logic        mem_wready,
  input  logic        mem_wvalid,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  output logic        mem_rready,
  input  logic        mem_rvalid,
  output logic [31:0] mem_raddr,
  input  logic        mem_rresp,
  input  logic [31:0] mem_rdata,
  // MMIO register block
  output logic        io_wready,
  input  logic        io_wvalid,
  output logic [31:0] io_waddr,
  output logic [31:0] io_wdata,
  output logic [3:0]  io_wstrb,
  output logic        io_rready,
  input  logic        io_rvalid,
  output logic [31:0] io_raddr,
  input  logic        io_rresp,
  input  logic [31:0] io_rdata,
  output logic        bus_err
);

  localparam int             CW       = $clog2(TIMEOUT);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

  tgt_sel_e      wsel, rsel;
  rd_state_e     state, state_nxt;
  logic [CW-1:0] cnt;
  logic          wr_err_q;
  logic          rd_acc;
  logic          tmo;

  dbus_decode #(.DMEM_BASE(DMEM_BASE), .DMEM_SIZE(DMEM_SIZE),
                .MMIO_BASE(MMIO_BASE), .MMIO_SIZE(MMIO_SIZE))
    u_wdec (.addr(core_waddr), .sel(wsel));

  dbus_decode #(.DMEM_BASE(DMEM_BASE), .DMEM_SIZE(DMEM_SIZE),
                .MMIO_BASE(MMIO_BASE), .MMIO_SIZE(MMIO_SIZE))
    u_rdec (.addr(core_raddr), .sel(rsel));

  assign mem_waddr = core_waddr;
  assign mem_wdata = core_wdata;
  assign mem_wstrb = core_wstrb;
  assign io_waddr  = core_waddr;
  assign io_wdata  = core_wdata;
  assign io_wstrb  = core_wstrb;
  assign mem_raddr = core_raddr;
  assign io_raddr  = core_raddr;

  // Write path: steer request to the hit target; unmapped writes are always accepted.
  always_comb begin
    mem_wready = core_wready & (wsel == SEL_MEM);
    io_wready  = core_wready & (wsel == SEL_IO);
    case (wsel)
      SEL_MEM: core_wvalid = mem_wvalid;
      SEL_IO:  core_wvalid = io_wvalid;
      default: core_wvalid = 1'b1;
    endcase
  end

  // Read request: only accepted from IDLE, gated by the addressed target's readiness.
  always_comb begin
    core_rvalid = 1'b0;
    if (state == ST_IDLE) begin
      case (rsel)
        SEL_MEM: core_rvalid = mem_rvalid;
        SEL_IO:  core_rvalid = io_rvalid;
        default: core_rvalid = 1'b1;
      endcase
    end
    rd_acc     = core_rready & core_rvalid;
    mem_rready = rd_acc & (rsel == SEL_MEM);
    io_rready  = rd_acc & (rsel == SEL_IO);
  end

  // Read FSM next state and response; responses only leave WAIT/ERR states,
  // so target responses arriving in IDLE or the wrong WAIT state are dropped.
  always_comb begin
    state_nxt  = state;
    core_rresp = 1'b0;
    core_rdata = '0;
    tmo        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rd_acc) begin
          case (rsel)
            SEL_MEM: state_nxt = ST_WAIT_MEM;
            SEL_IO:  state_nxt = ST_WAIT_IO;
            default: state_nxt = ST_ERR;
          endcase
        end
      end
      ST_WAIT_MEM: begin
        if (mem_rresp) begin
          core_rresp = 1'b1;
          core_rdata = mem_rdata;
          state_nxt  = ST_IDLE;
        end else if (cnt == CNT_LAST) begin
          core_rresp = 1'b1;
          core_rdata = BUS_ERR_DATA;
          tmo        = 1'b1;
          state_nxt  = ST_DRAIN;
        end
      end
      ST_WAIT_IO: begin
        core_rresp = io_rresp;
        core_rdata = io_rresp ? io_rdata : '0;
        state_nxt  = ST_IDLE;
      end
      ST_ERR: begin
        core_rresp = 1'b1;
        state_nxt  = ST_IDLE;
      end
      ST_DRAIN: begin
        // swallow the late memory response so it cannot satisfy a later read
        if (mem_rresp) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    // a read in flight while reset is held is abandoned, not answered
    if (resetb) begin
      core_rresp = 1'b0;
      core_rdata = '0;
    end
  end

  // Write and read errors share one pulse when they land in the same cycle.
  assign bus_err = ~resetb & (wr_err_q | (state == ST_ERR) | tmo);

  // Read FSM state register.
  always_ff @(posedge clk) begin
    if (resetb) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Timeout counter: runs only while waiting on memory, zero on entry.
  always_ff @(posedge clk) begin
    if (resetb || state != ST_WAIT_MEM) cnt <= '0;
    else                                cnt <= cnt + CW'(1);
  end

  // Unmapped write flag, reported as bus_err the following cycle.
  always_ff @(posedge clk) begin
    if (resetb) wr_err_q <= 1'b0;
    else        wr_err_q <= core_wready & (wsel == SEL_NONE);
  end

endmodule

// File: tb/tb_dbus_bridge.sv
// Scoreboard bench for dbus_bridge: drivers push expected read responses,
// writes and bus_err cycles into queues; monitors pop and compare.
module tb_dbus_bridge;

  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic resetb = 1'b1;
  always #5 clk = ~clk;

  logic        core_wready = 0, core_wvalid;
  logic [31:0] core_waddr = 0, core_wdata = 0;
  logic [3:0]  core_wstrb = 0;
  logic        core_rready = 0, core_rvalid;
  logic [31:0] core_raddr = 0;
  logic        core_rresp;
  logic [31:0] core_rdata;
  logic        mem_wready, mem_wvalid = 1;
  logic [31:0] mem_waddr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_rready, mem_rvalid = 1;
  logic [31:0] mem_raddr;
  logic        mem_rresp;
  logic [31:0] mem_rdata = 0;
  logic        io_wready, io_wvalid = 1;
  logic [31:0] io_waddr, io_wdata;
  logic [3:0]  io_wstrb;
  logic        io_rready, io_rvalid = 1;
  logic [31:0] io_raddr;
  logic        io_rresp;
  logic [31:0] io_rdata = 0;
  logic        bus_err;

  logic mr_model = 0, mr_spur = 0, ir_model = 0, ir_spur = 0;
  assign mem_rresp = mr_model | mr_spur;
  assign io_rresp  = ir_model | ir_spur;

  dbus_bridge #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .resetb(resetb),
    .core_wready(core_wready), .core_wvalid(core_wvalid), .core_waddr(core_waddr),
    .core_wdata(core_wdata), .core_wstrb(core_wstrb),
    .core_rready(core_rready), .core_rvalid(core_rvalid), .core_raddr(core_raddr),
    .core_rresp(core_rresp), .core_rdata(core_rdata),
    .mem_wready(mem_wready), .mem_wvalid(mem_wvalid), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rready(mem_rready), .mem_rvalid(mem_rvalid), .mem_raddr(mem_raddr),
    .mem_rresp(mem_rresp), .mem_rdata(mem_rdata),
    .io_wready(io_wready), .io_wvalid(io_wvalid), .io_waddr(io_waddr),
    .io_wdata(io_wdata), .io_wstrb(io_wstrb),
    .io_rready(io_rready), .io_rvalid(io_rvalid), .io_raddr(io_raddr),
    .io_rresp(io_rresp), .io_rdata(io_rdata),
    .bus_err(bus_err)
  );

  typedef struct { logic [31:0] data; int cyc; } rexp_t;
  typedef struct { int tgt; logic [31:0] addr; logic [31:0] data; logic [3:0] strb; } wexp_t;

  rexp_t rq[$];
  wexp_t wq[$];
  int    eq[$];
  int    n_cmp = 0, n_bad = 0;
  int    cyc = 0;

  int          next_lat = 1;
  logic [31:0] next_md = 0, next_io = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference address map: 0 = memory, 1 = MMIO, 2 = unmapped.
  function automatic int ref_sel(logic [31:0] a);
    if (a < 32'h0002_0000) return 0;
    if (a >= 32'h9000_0000 && a <= 32'h9000_0FFF) return 1;
    return 2;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Memory model: answers an accepted read next_lat cycles later.
  initial begin : mem_resp_model
    int l;
    logic [31:0] d;
    forever begin
      @(negedge clk);
      if (mem_rready) begin
        l = next_lat; d = next_md;
        repeat (l) @(posedge clk);
        #1 mr_model = 1; mem_rdata = d;
        @(posedge clk);
        #1 mr_model = 0; mem_rdata = $urandom;
      end
    end
  end

  // MMIO model: answers one cycle after the request.
  initial begin : io_resp_model
    logic [31:0] d;
    forever begin
      @(negedge clk);
      if (io_rready) begin
        d = next_io;
        @(posedge clk);
        #1 ir_model = 1; io_rdata = d;
        @(posedge clk);
        #1 ir_model = 0; io_rdata = $urandom;
      end
    end
  end

  // Monitor: read responses, bus_err pulses and write handshakes vs scoreboard.
  rexp_t re;
  wexp_t we;
  always @(negedge clk) begin
    if (core_rresp) begin
      if (rq.size() == 0) chk("unexpected_rresp", 32'(core_rresp), 32'd0);
      else begin
        re = rq.pop_front();
        chk("rdata", core_rdata, re.data);
        chk("rresp_cycle", 32'(cyc), 32'(re.cyc));
      end
    end else if (rq.size() > 0 && rq[0].cyc < cyc) begin
      chk("missing_rresp", 32'(core_rresp), 32'd1);
      void'(rq.pop_front());
    end
    if (bus_err) begin
      if (eq.size() == 0) chk("unexpected_bus_err", 32'(bus_err), 32'd0);
      else chk("bus_err_cycle", 32'(cyc), 32'(eq.pop_front()));
    end else if (eq.size() > 0 && eq[0] < cyc) begin
      chk("missing_bus_err", 32'(bus_err), 32'd1);
      void'(eq.pop_front());
    end
    if ((mem_wready && mem_wvalid) || (io_wready && io_wvalid)) begin
      if (wq.size() == 0) chk("unexpected_write", {30'd0, mem_wready, io_wready}, 32'd0);
      else begin
        we = wq.pop_front();
        chk("wr_target", {30'd0, io_wready, mem_wready}, (we.tgt == 0) ? 32'd1 : 32'd2);
        chk("wr_addr", (we.tgt == 0) ? mem_waddr : io_waddr, we.addr);
        chk("wr_data", (we.tgt == 0) ? mem_wdata : io_wdata, we.data);
        chk("wr_strb", 32'((we.tgt == 0) ? mem_wstrb : io_wstrb), 32'(we.strb));
      end
    end
  end

  task automatic do_write(logic [31:0] a, logic [31:0] d, logic [3:0] s, int stall);
    int t, n;
    t = ref_sel(a); n = 0;
    @(posedge clk); #1;
    core_waddr = a; core_wdata = d; core_wstrb = s; core_wready = 1;
    mem_wvalid = (stall == 0); io_wvalid = (stall == 0);
    if (t != 2) wq.push_back('{t, a, d, s});
    forever begin
      @(negedge clk);
      if (core_wvalid || n > 40) break;
      n++;
      @(posedge clk); #1;
      if (n >= stall) begin mem_wvalid = 1; io_wvalid = 1; end
    end
    chk("wr_accept_wait", 32'(n), (t == 2) ? 32'd0 : 32'(stall));
    if (t == 2) eq.push_back(cyc + 1);
    @(posedge clk); #1;
    core_wready = 0; mem_wvalid = 1; io_wvalid = 1;
  endtask

  task automatic do_read(logic [31:0] a, int lat, logic [31:0] md, logic [31:0] iod, bit spur);
    int t, n, acc, busy;
    t = ref_sel(a); n = 0; busy = 1;
    @(posedge clk); #1;
    next_lat = lat; next_md = md; next_io = iod;
    core_raddr = a; core_rready = 1;
    forever begin
      @(negedge clk);
      if (core_rvalid || n > 40) break;
      n++;
    end
    chk("rd_accept", 32'(core_rvalid), 32'd1);
    acc = cyc;
    case (t)
      0: begin
        busy = lat;
        if (lat <= TIMEOUT) rq.push_back('{md, acc + lat});
        else begin
          rq.push_back('{32'hDEAD_BEEF, acc + TIMEOUT});
          eq.push_back(acc + TIMEOUT);
        end
      end
      1: rq.push_back('{iod, acc + 1});
      default: begin
        rq.push_back('{32'h0, acc + 1});
        eq.push_back(acc + 1);
      end
    endcase
    @(posedge clk); #1;
    core_rready = 0;
    if (spur) begin
      if (t == 0) ir_spur = 1;
      else        mr_spur = 1;
    end
    for (int i = 1; i <= busy; i++) begin
      @(negedge clk);
      chk("rvalid_busy", 32'(core_rvalid), 32'd0);
      if (i == 1) begin
        @(posedge clk); #1;
        ir_spur = 0; mr_spur = 0;
      end
    end
    @(negedge clk);
    chk("rvalid_idle", 32'(core_rvalid), 32'd1);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] um [6];
    um = '{32'h4000_0000, 32'h0002_0000, 32'h8FFF_FFFC, 32'h9000_1000, 32'hFFFF_FFFC, 32'h2000_0000};
    case ($urandom_range(0, 5))
      0, 1:    return $urandom_range(0, 32'h1FFFF) & 32'hFFFF_FFFC;
      2, 3:    return 32'h9000_0000 + ($urandom_range(0, 32'hFFF) & 32'hFFC);
      4:       return um[$urandom_range(0, 5)];
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_rresp", 32'(core_rresp), 32'd0);
    chk("reset_rdata", core_rdata, 32'd0);
    chk("reset_bus_err", 32'(bus_err), 32'd0);
    @(posedge clk); #1 resetb = 0;
    @(negedge clk);
    chk("reset_rvalid", 32'(core_rvalid), 32'd1);

    // directed
    do_write(32'h9000_0008, 32'h1234_5678, 4'hF, 0);
    do_read(32'h0000_0100, 3, 32'hCAFE_F00D, 32'h0, 0);
    do_read(32'h9000_0000, 1, 32'h0, 32'h5, 0);
    do_read(32'h4000_0000, 1, 32'h0, 32'h0, 0);
    do_write(32'h4000_0000, 32'hAAAA_5555, 4'h3, 0);
    do_read(32'h0000_0040, 24, 32'hBAD0_0001, 32'h0, 0);
    do_read(32'h0001_FFFC, TIMEOUT, 32'h0BAD_F00D, 32'h0, 0);
    do_read(32'h0001_FFF8, TIMEOUT + 1, 32'h7777_0000, 32'h0, 0);
    do_read(32'h0002_0000, 1, 32'h0, 32'h0, 0);
    do_read(32'h9000_0FFC, 1, 32'h0, 32'h1357_9BDF, 1);
    do_read(32'h0000_0800, 4, 32'h2468_ACE0, 32'h0, 1);
    do_write(32'h9000_1000, 32'h1, 4'h1, 0);
    do_write(32'h0001_0000, 32'h89AB_CDEF, 4'hC, 2);
    do_read(32'h8FFF_FFFC, 1, 32'h0, 32'h0, 1);

    // unmapped write and unmapped read in the same cycle: one bus_err pulse
    @(posedge clk); #1;
    core_waddr = 32'h4000_0000; core_wdata = 32'h1; core_wstrb = 4'hF; core_wready = 1;
    core_raddr = 32'h4000_0010; core_rready = 1;
    @(negedge clk);
    chk("sim_rvalid", 32'(core_rvalid), 32'd1);
    chk("sim_wvalid", 32'(core_wvalid), 32'd1);
    rq.push_back('{32'h0, cyc + 1});
    eq.push_back(cyc + 1);
    @(posedge clk); #1;
    core_wready = 0; core_rready = 0;
    repeat (3) @(negedge clk);

    // target responses while idle must not reach the core
    @(posedge clk); #1 mr_spur = 1; ir_spur = 1;
    @(negedge clk);
    chk("idle_spur_rresp", 32'(core_rresp), 32'd0);
    @(posedge clk); #1 mr_spur = 0; ir_spur = 0;

    // reset during WAIT_MEM; the late response arrives in IDLE and is dropped
    @(posedge clk); #1;
    next_lat = 6; next_md = 32'h1111_2222; core_raddr = 32'h0000_0200; core_rready = 1;
    @(negedge clk);
    chk("rst_rd_accept", 32'(core_rvalid), 32'd1);
    @(posedge clk); #1 core_rready = 0;
    @(posedge clk); #1 resetb = 1;
    @(negedge clk);
    chk("rst_mid_rresp", 32'(core_rresp), 32'd0);
    chk("rst_mid_bus_err", 32'(bus_err), 32'd0);
    @(posedge clk); #1 resetb = 0;
    @(negedge clk);
    chk("rst_mid_rvalid", 32'(core_rvalid), 32'd1);
    repeat (6) @(negedge clk);
    do_read(32'h0000_0300, 2, 32'h3333_4444, 32'h0, 0);

    // randomized traffic
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 2) == 0)
        do_write(rand_addr(), $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2));
      else
        do_read(rand_addr(), $urandom_range(1, 20), $urandom, $urandom, 1'($urandom_range(0, 1)));
    end

    repeat (5) @(negedge clk);
    chk("rq_drained", 32'(rq.size()), 32'd0);
    chk("eq_drained", 32'(eq.size()), 32'd0);
    chk("wq_drained", 32'(wq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dbus_bridge.md
Name: dbus_bridge

Overview:
- Routes the core's data-bus port to two targets: data memory, and the MMIO peripheral slave (timer/software/external-IRQ register block).
- Decodes each address, forwards write requests combinationally, and tracks one outstanding read with a small FSM.
- Sits between the core's data port and the data memory / CLINT-style MMIO register block.
- Unmapped accesses and memory read timeouts complete with an error response, so the core never hangs.

Parameters:
- DMEM_BASE, 32'h0000_0000, data memory base address.
- DMEM_SIZE, 32'h0002_0000, data memory size in bytes (power of two).
- MMIO_BASE, 32'h9000_0000, MMIO window base.
- MMIO_SIZE, 32'h0000_1000, MMIO window size in bytes (power of two).
- TIMEOUT, 16, max cycles waiting for a memory read response (>=2).

Ports:
- clk  input  1  clock
- resetb  input  1  reset; synchronous, active-high
- core_wready  input  1  core write request
- core_wvalid  output  1  bridge can accept write
- core_waddr  input  32  write address
- core_wdata  input  32  write data
- core_wstrb  input  4  byte strobes
- core_rready  input  1  core read request
- core_rvalid  output  1  bridge can accept read
- core_raddr  input  32  read address
- core_rresp  output  1  read data valid
- core_rdata  output  32  read data
- mem_wready / mem_wvalid / mem_waddr / mem_wdata / mem_wstrb  out/in/out/out/out  1/1/32/32/4  memory write port
- mem_rready / mem_rvalid / mem_raddr  out/in/out  1/1/32  memory read request
- mem_rresp / mem_rdata  in/in  1/32  memory read response
- io_wready / io_wvalid / io_waddr / io_wdata / io_wstrb  out/in/out/out/out  1/1/32/32/4  MMIO write port
- io_rready / io_rvalid / io_raddr  out/in/out  1/1/32  MMIO read request
- io_rresp / io_rdata  in/in  1/32  MMIO response (one cycle after request)
- bus_err  output  1  one-cycle pulse on unmapped access or timeout

Behaviour:
- Decode: hit_mem = (addr - DMEM_BASE) < DMEM_SIZE; hit_io = (addr - MMIO_BASE) < MMIO_SIZE; neither = unmapped. Use 32-bit unsigned compare, so addresses below base wrap and miss.
- Write path (combinational, independent of read FSM):
  - core_wvalid = hit_mem ? mem_wvalid : hit_io ? io_wvalid : 1.
  - mem_wready = core_wready & hit_mem; io_wready = core_wready & hit_io.
  - Address, data and strobes pass through unchanged.
  - Unmapped write is accepted, dropped, and pulses bus_err on the next cycle.
- Read FSM states: IDLE, WAIT_MEM, WAIT_IO, ERR, DRAIN.
  - core_rvalid = (state==IDLE) & (hit_mem ? mem_rvalid : hit_io ? io_rvalid : 1). It is 0 in all other states.
  - target rready = core_rready & core_rvalid & hit_target. raddr passes through.
- Accept in IDLE goes to WAIT_MEM, WAIT_IO or ERR. The timeout counter clears on entry to WAIT_MEM.
- WAIT_MEM:
  - mem_rresp → core_rresp=1, core_rdata=mem_rdata in the same cycle (combinational), then IDLE.
  - Otherwise the counter increments. At count==TIMEOUT-1 without a response: core_rresp=1, core_rdata=32'hDEAD_BEEF, bus_err=1, go to DRAIN.
- WAIT_IO: forward io_rresp/io_rdata combinationally, then IDLE.
- ERR: core_rresp=1, core_rdata=32'h0, bus_err=1 for one cycle, then IDLE.
- DRAIN: core_rvalid=0; wait for mem_rresp, discard it, then IDLE. This prevents a stale response from matching a later read.
- Target rresp seen in IDLE or in the wrong WAIT state: ignored, never forwarded.
- Simultaneous write and read in one cycle: both proceed independently. A write to the address being read has no ordering guarantee beyond target behaviour.
- bus_err for a simultaneous unmapped write and a read error: a single pulse.
- Reset (synchronous): state=IDLE, counter=0, core_rresp=0, bus_err=0, core_rdata=0.
  - Reset asserted mid-read abandons the read; a late target response is ignored.
  - core_rresp/core_rdata are gated by state, so they read 0 whenever state is IDLE.

Decomposition:
- Shared package: DMEM_BASE/MMIO_BASE defaults, FSM state encoding, BUS_ERR_DATA (32'hDEAD_BEEF), target-select enum (SEL_MEM, SEL_IO, SEL_NONE).
- One natural sub-module: dbus_decode (address → target-select, purely combinational). It is instantiated twice, for waddr and raddr.

Test Plan:
- Write 32'h1234_5678 to 32'h9000_0008 with strb 4'hF → io_wready=1 for one cycle, mem_wready=0, bus_err=0.
- Read 32'h0000_0100, mem_rresp 3 cycles later with 32'hCAFE_F00D → core_rresp=1 in that cycle with data 32'hCAFE_F00D; core_rvalid=0 during the wait.
- Read 32'h9000_0000, io_rresp next cycle with 32'h5 → core_rdata=32'h5 exactly 1 cycle after accept.
- Read unmapped 32'h4000_0000 → core_rresp=1 and core_rdata=0 on the next cycle, bus_err pulse; write there → dropped, bus_err pulse.
- Memory read never answered → at cycle 16 core_rresp=1, data 32'hDEAD_BEEF, bus_err; core_rvalid stays 0 until the late mem_rresp is drained.
- Assert resetb during WAIT_MEM, then mem_rresp arrives → core_rresp stays 0 and the next read completes normally.
